// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register offsets, debounce counter width and W1C helper for mmio_periph_bank
package mmio_pkg;
   localparam logic [31:0] OFS_KEY_LEVEL  = 32'h00;
   localparam logic [31:0] OFS_KEY_EVENT  = 32'h04;
   localparam logic [31:0] OFS_KEY_IRQ_EN = 32'h08;
   localparam logic [31:0] OFS_CTL0       = 32'h10;

   localparam int DEB_CNT_W = 16;

   // A set arriving in the same cycle as a clear wins, so no key event is ever lost.
   function automatic logic [31:0] w1c_update(input logic [31:0] cur,
                                              input logic [31:0] set,
                                              input logic [31:0] clr,
                                              input logic        clr_en);
      logic [31:0] kept;
      kept = clr_en ? (cur & ~clr) : cur;
      return kept | set;
   endfunction
endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: 2-flop synchronizer, stability counter and level register
// MMIO_DEBOUNCE_EN enables the counter; otherwise the level follows the synchronizer.
module key_debounce
   import mmio_pkg::*;
#(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key_n,
   output logic o_level,
   output logic o_rise
);
   logic r_sync1;
   logic r_sync2;
   logic r_level;
   logic w_next_level;

   // Inverted at the input so the synchronizer resets to "released".
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= ~i_key_n;
         r_sync2 <= r_sync1;
      end
   end

`ifdef MMIO_DEBOUNCE_EN
   localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

   logic [DEB_CNT_W-1:0] r_cnt;
   logic                 w_differ;
   logic                 w_expire;

   assign w_differ     = r_sync2 != r_level;
   assign w_expire     = w_differ && (r_cnt == CNT_LAST);
   assign w_next_level = w_expire ? r_sync2 : r_level;

   always_ff @(posedge clk) begin
      if (rst || !w_differ || w_expire) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DEB_CNT_W'(1);
      end
   end
`else
   // Without the counter DEB_CYCLES has no effect on the path.
   if (DEB_CYCLES > 0) begin : g_direct
      assign w_next_level = r_sync2;
   end else begin : g_direct_any
      assign w_next_level = r_sync2;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_level <= 1'b0;
      end else begin
         r_level <= w_next_level;
      end
   end

   assign o_level = r_level;
   assign o_rise  = w_next_level & ~r_level;
endmodule

// File: rtl/mmio_periph_bank.sv
// rtl/mmio_periph_bank.sv - MMIO bank: keys with W1C events and level irq, plus RW control registers
// Define MMIO_DEBOUNCE_EN to debounce keys over DEB_CYCLES clocks.
module mmio_periph_bank
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFFFFE0,
   parameter int          NUM_IN     = 4,
   parameter int          NUM_CTL    = 4,
   parameter int          DEB_CYCLES = 50000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            addr,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            wdata,
   output logic [31:0]            rdata,
   output logic                   rdata_valid,
   output logic                   data_oen_n,
   input  logic [NUM_IN-1:0]      key_n,
   output logic [32*NUM_CTL-1:0]  ctl_out,
   output logic                   irq
);
   localparam logic [29:0] W_LEVEL  = OFS_KEY_LEVEL[31:2];
   localparam logic [29:0] W_EVENT  = OFS_KEY_EVENT[31:2];
   localparam logic [29:0] W_IRQ_EN = OFS_KEY_IRQ_EN[31:2];
   localparam logic [29:0] W_CTL0   = OFS_CTL0[31:2];
   localparam logic [29:0] W_END    = W_CTL0 + 30'(NUM_CTL);

   logic [29:0]       w_wofs;
   logic              w_hit;
   logic              w_wr;
   logic              w_rd;
   logic              w_wr_event;
   logic              w_unused_addr_lsb;
   logic [NUM_IN-1:0] w_level;
   logic [NUM_IN-1:0] w_rise;
   logic [NUM_IN-1:0] r_event;
   logic [NUM_IN-1:0] r_irq_en;
   logic [31:0]       r_ctl [NUM_CTL];
   logic [31:0]       w_rd_mux;
   logic [31:0]       r_rdata;
   logic              r_rvalid;
   logic              r_irq;

   // Word offset from the base; wrap-around makes addresses below the base miss too.
   assign w_wofs            = addr[31:2] - BASE_ADDR[31:2];
   assign w_hit             = w_wofs < W_END;
   assign w_wr              = wr_en & w_hit;
   assign w_rd              = rd_en & w_hit;
   assign w_wr_event        = w_wr && (w_wofs == W_EVENT);
   assign w_unused_addr_lsb = ^addr[1:0];

   for (genvar k = 0; k < NUM_IN; k++) begin : g_key
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
         .clk     (clk),
         .rst     (rst),
         .i_key_n (key_n[k]),
         .o_level (w_level[k]),
         .o_rise  (w_rise[k])
      );
   end

   for (genvar i = 0; i < NUM_CTL; i++) begin : g_ctl_out
      assign ctl_out[32*i +: 32] = r_ctl[i];
   end

   always_comb begin
      w_rd_mux = '0;
      if (w_wofs == W_LEVEL) begin
         w_rd_mux = 32'(w_level);
      end else if (w_wofs == W_EVENT) begin
         w_rd_mux = 32'(r_event);
      end else if (w_wofs == W_IRQ_EN) begin
         w_rd_mux = 32'(r_irq_en);
      end
      for (int i = 0; i < NUM_CTL; i++) begin
         if (w_wofs == W_CTL0 + 30'(i)) begin
            w_rd_mux = r_ctl[i];
         end
      end
   end

   // Reads sample the pre-write state, so a same-cycle write is not visible to its read.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CTL; i++) begin
            r_ctl[i] <= '0;
         end
         r_event  <= '0;
         r_irq_en <= '0;
         r_irq    <= 1'b0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_event <= NUM_IN'(w1c_update(32'(r_event), 32'(w_rise), wdata, w_wr_event));
         if (w_wr && (w_wofs == W_IRQ_EN)) begin
            r_irq_en <= wdata[NUM_IN-1:0];
         end
         for (int i = 0; i < NUM_CTL; i++) begin
            if (w_wr && (w_wofs == W_CTL0 + 30'(i))) begin
               r_ctl[i] <= wdata;
            end
         end
         r_irq    <= |(r_event & r_irq_en);
         r_rvalid <= w_rd;
         r_rdata  <= w_rd ? w_rd_mux : '0;
      end
   end

   assign rdata       = r_rdata;
   assign rdata_valid = r_rvalid;
   assign data_oen_n  = ~w_hit;
   assign irq         = r_irq;
endmodule
